hoop_renderer: RTL

Parametrised, clocked successor to the static hoop sprite. It draws the rim, backboard and pole relative to a run-time hoop position. Optionally, it oscillates the hoop vertically once per frame, and it flashes the rim for a programmable number of frames after a score event. It sits in the VGA pixel path beside the ball renderer, and it exports the live rim position to the collision/score logic.

---
 rtl/hoop_renderer_pkg.sv | 18 +
 rtl/hoop_flash_ctrl.sv | 72 +++++++
 rtl/hoop_renderer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hoop_renderer_pkg.sv
// Shared constants and state encodings for the hoop renderer.
// Colours are 12-bit {R,G,B}, 4 bits per channel.
// Screen limits match the 640x480 VGA timing used by the pixel path.
package hoop_renderer_pkg;

  localparam logic [11:0] GRAY   = 12'h555;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] YELLOW = 12'hFF0;

  localparam int H_MAX = 640;
  localparam int V_MAX = 480;

  typedef enum logic {MV_UP, MV_DOWN} motion_e;
  typedef enum logic {FL_IDLE, FL_FLASH} flash_e;

endpackage

// File: rtl/hoop_flash_ctrl.sv
// Score flash controller: runs for FLASH_FRAMES frames after a score pulse.
// State changes only on score or frame_tick; outputs are register-driven.
// No backpressure: score always reloads, even mid-flash or on the final tick.
module hoop_flash_ctrl
  import hoop_renderer_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic score,
  output logic flashing,
  output logic phase
);

  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  flash_e        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          phase_q, phase_d;

  // State, frame counter and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FL_IDLE;
      fcnt_q  <= '0;
      pcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pcnt_q  <= pcnt_d;
      phase_q <= phase_d;
    end
  end

  // Next state: score reloads unconditionally and beats a coincident tick.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pcnt_d  = pcnt_q;
    phase_d = phase_q;
    if (score) begin
      state_d = FL_FLASH;
      fcnt_d  = FW'(FLASH_FRAMES - 1);
      pcnt_d  = '0;
      phase_d = 1'b0;
    end else if (state_q == FL_FLASH && frame_tick) begin
      if (fcnt_q == '0) begin
        state_d = FL_IDLE;
        pcnt_d  = '0;
        phase_d = 1'b0;
      end else begin
        fcnt_d = fcnt_q - FW'(1);
        if (pcnt_q == PW'(FLASH_PERIOD - 1)) begin
          pcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
    end
  end

  assign flashing = (state_q == FL_FLASH);
  assign phase    = phase_q;

endmodule

// File: rtl/hoop_renderer.sv
// Draws rim, backboard and pole around a run-time hoop position; oscillates and flashes.
// Pixel path latency 1 cycle; position/flash update only on frame_tick.
// No backpressure: produces one registered pixel result every clock.
module hoop_renderer
  import hoop_renderer_pkg::*;
#(
  parameter int RIM_W        = 20,
  parameter int RIM_H        = 4,
  parameter int BOARD_W      = 4,
  parameter int BOARD_H      = 61,
  parameter int BOARD_Y_OFS  = 54,
  parameter int POLE_W       = 6,
  parameter int POLE_Y_OFS   = 34,
  parameter int HOME_X       = 610,
  parameter int HOME_Y       = 254,
  parameter int MOVE_RANGE   = 40,
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        move_en,
  input  logic        score,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [11:0] object_rgb,
  output logic        object_on,
  output logic [9:0]  hoop_x,
  output logic [9:0]  hoop_y,
  output logic        flashing
);

  localparam logic [9:0] TOP_Y  = 10'(HOME_Y - MOVE_RANGE);
  localparam logic [9:0] BOT_Y  = 10'(HOME_Y);

  localparam logic signed [10:0] RIM_W_S   = 11'(RIM_W);
  localparam logic signed [10:0] RIM_H_S   = 11'(RIM_H);
  localparam logic signed [10:0] BOARD_W_S = 11'(BOARD_W);
  localparam logic signed [10:0] BOARD_H_S = 11'(BOARD_H);
  localparam logic signed [10:0] BOARD_OFS = 11'(BOARD_Y_OFS);
  localparam logic signed [10:0] POLE_W_S  = 11'(POLE_W);
  localparam logic signed [10:0] POLE_OFS  = 11'(POLE_Y_OFS);
  localparam logic signed [10:0] LAST_ROW  = 11'(V_MAX - 1);

  motion_e     dir_q, dir_d;
  logic [9:0]  hy_q, hy_d;
  logic [11:0] rgb_q, rgb_d;
  logic        on_q, on_d;
  logic        phase;

  logic signed [10:0] px_s, py_s, hx_s, hy_s, side_x, board_top, pole_top;
  logic               rim_hit, board_hit, pole_hit;

  hoop_flash_ctrl #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_PERIOD(FLASH_PERIOD)
  ) u_flash (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .score      (score),
    .flashing   (flashing),
    .phase      (phase)
  );

  // Motion state and registered pixel output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= MV_UP;
      hy_q  <= BOT_Y;
      rgb_q <= BLACK;
      on_q  <= 1'b0;
    end else begin
      dir_q <= dir_d;
      hy_q  <= hy_d;
      rgb_q <= rgb_d;
      on_q  <= on_d;
    end
  end

  // Vertical oscillation: a turnaround tick reverses direction without moving.
  always_comb begin
    dir_d = dir_q;
    hy_d  = hy_q;
    if (frame_tick && move_en) begin
      if (dir_q == MV_UP) begin
        if (hy_q == TOP_Y) dir_d = MV_DOWN;
        else               hy_d  = hy_q - 10'd1;
      end else begin
        if (hy_q == BOT_Y) dir_d = MV_UP;
        else               hy_d  = hy_q + 10'd1;
      end
    end
  end

  // Geometry compare in 11-bit signed so offsets above the rim cannot wrap.
  always_comb begin
    px_s      = signed'({1'b0, pixel_x});
    py_s      = signed'({1'b0, pixel_y});
    hx_s      = 11'(HOME_X);
    hy_s      = signed'({1'b0, hy_q});
    side_x    = hx_s + RIM_W_S;
    board_top = hy_s - BOARD_OFS;
    pole_top  = hy_s - POLE_OFS;
    rim_hit   = (px_s >= hx_s) && (px_s < side_x) &&
                (py_s >= hy_s) && (py_s < hy_s + RIM_H_S);
    board_hit = (px_s >= side_x) && (px_s < side_x + BOARD_W_S) &&
                (py_s >= board_top) && (py_s < board_top + BOARD_H_S);
    pole_hit  = (px_s >= side_x) && (px_s < side_x + POLE_W_S) &&
                (py_s >= pole_top) && (py_s <= LAST_ROW);
  end

  // Colour select with rim > board > pole priority; blanking forces black.
  always_comb begin
    on_d  = 1'b0;
    rgb_d = BLACK;
    if (video_on) begin
      if (rim_hit) begin
        on_d  = 1'b1;
        rgb_d = (flashing && phase) ? YELLOW : RED;
      end else if (board_hit) begin
        on_d  = 1'b1;
        rgb_d = WHITE;
      end else if (pole_hit) begin
        on_d  = 1'b1;
        rgb_d = GRAY;
      end
    end
  end

  assign object_rgb = rgb_q;
  assign object_on  = on_q;
  assign hoop_x     = 10'(HOME_X);
  assign hoop_y     = hy_q;

endmodule
